// File: rtl/wght_bank_ctrl_if.sv
// wght_bank_ctrl_if: load stream, read control and kernel delivery signals of the weight bank.
interface wght_bank_ctrl_if #(parameter int W = 8, K = 5, AW = 3);
  logic              load_start;
  logic              wr_valid;
  logic [W-1:0]      wr_data;
  logic              wr_ready;
  logic              write_complete;
  logic              loaded;
  logic              start;
  logic [1:0]        mode;
  logic [AW-1:0]     rd_addr;
  logic              stop;
  logic              bank_valid;
  logic              bank_ready;
  logic [K*K*W-1:0]  bank_data;
  logic [AW-1:0]     bank_idx;
  logic              bank_last;
  logic              done;
  logic              err;
  logic              busy;
  modport master (
    output load_start, wr_valid, wr_data, start, mode, rd_addr, stop, bank_ready,
    input  wr_ready, write_complete, loaded, bank_valid, bank_data, bank_idx, bank_last, done, err, busy
  );
  modport slave (
    input  load_start, wr_valid, wr_data, start, mode, rd_addr, stop, bank_ready,
    output wr_ready, write_complete, loaded, bank_valid, bank_data, bank_idx, bank_last, done, err, busy
  );
endinterface

// File: rtl/wght_bank_ctrl.sv
// wght_bank_ctrl: serial-loaded kernel store delivering one packed KxK kernel per handshake.
module wght_bank_ctrl #(
  parameter int W  = 8,
  parameter int K  = 5,
  parameter int L  = 6,
  parameter int C  = 1,
  parameter int AW = (L*C > 1) ? $clog2(L*C) : 1
) (
  input logic clk,
  input logic rst,
  wght_bank_ctrl_if.slave b
);
  localparam int N  = L*C;
  localparam int KK = K*K;
  localparam int SW = (KK > 1) ? $clog2(KK) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, READ = 2'd2;

  logic [KK*W-1:0] kern_q [N];
  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [NW-1:0]   kidx_q, kidx_d;
  logic            loaded_q, loaded_d, wc_q, wc_d, err_q, err_d, done_q, done_d;
  logic            bv_q, bv_d, blast_q, blast_d, loop_q, loop_d, stop_q, stop_d;
  logic [AW-1:0]   bidx_q, bidx_d, nidx;
  logic [KK*W-1:0] bdata_q, bdata_d;
  logic            wr_en, last_word, bad_start, fin;

  assign wr_en     = state_q == LOAD && b.wr_valid && !b.load_start;
  assign last_word = kidx_q == NW'(N-1) && slot_q == SW'(KK-1);
  assign bad_start = !loaded_q || (b.mode == 2'd2 && int'(b.rd_addr) >= N);
  // stop may arrive in the very cycle of the last handshake
  assign fin       = bv_q && b.bank_ready && blast_q && (!loop_q || stop_q || b.stop);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    kidx_d   = kidx_q;
    loaded_d = loaded_q;
    wc_d     = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    bv_d     = bv_q;
    blast_d  = blast_q;
    loop_d   = loop_q;
    stop_d   = stop_q;
    bidx_d   = bidx_q;
    bdata_d  = bdata_q;
    nidx     = b.mode == 2'd2 ? b.rd_addr : '0;
    if (b.load_start) begin
      state_d  = LOAD;
      slot_d   = '0;
      kidx_d   = '0;
      loaded_d = 1'b0;
      bv_d     = 1'b0;
      blast_d  = 1'b0;
    end else if (state_q == IDLE && b.start) begin
      err_d = bad_start;
      if (!bad_start) begin
        state_d = READ;
        loop_d  = b.mode == 2'd1;
        stop_d  = 1'b0;
        bv_d    = 1'b1;
        bidx_d  = nidx;
        blast_d = b.mode == 2'd2 || nidx == AW'(N-1);
        bdata_d = kern_q[NW'(nidx)];
      end
    end else if (wr_en) begin
      slot_d = slot_q == SW'(KK-1) ? '0 : slot_q + SW'(1);
      kidx_d = slot_q == SW'(KK-1) ? kidx_q + NW'(1) : kidx_q;
      if (last_word) begin
        state_d  = IDLE;
        wc_d     = 1'b1;
        loaded_d = 1'b1;
        kidx_d   = '0;
      end
    end else if (state_q == READ) begin
      stop_d = stop_q | b.stop;
      if (fin) begin
        state_d = IDLE;
        bv_d    = 1'b0;
        blast_d = 1'b0;
        done_d  = 1'b1;
      end else if (bv_q && b.bank_ready) begin
        nidx    = bidx_q == AW'(N-1) ? '0 : bidx_q + AW'(1);
        bidx_d  = nidx;
        blast_d = nidx == AW'(N-1);
        bdata_d = kern_q[NW'(nidx)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      kidx_q   <= '0;
      loaded_q <= 1'b0;
      wc_q     <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      bv_q     <= 1'b0;
      blast_q  <= 1'b0;
      loop_q   <= 1'b0;
      stop_q   <= 1'b0;
      bidx_q   <= '0;
      bdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      kidx_q   <= kidx_d;
      loaded_q <= loaded_d;
      wc_q     <= wc_d;
      err_q    <= err_d;
      done_q   <= done_d;
      bv_q     <= bv_d;
      blast_q  <= blast_d;
      loop_q   <= loop_d;
      stop_q   <= stop_d;
      bidx_q   <= bidx_d;
      bdata_q  <= bdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int j = 0; j < KK; j++)
        if (slot_q == SW'(j)) kern_q[kidx_q][j*W +: W] <= b.wr_data;
  end

  assign b.wr_ready       = state_q == LOAD;
  assign b.write_complete = wc_q;
  assign b.loaded         = loaded_q;
  assign b.bank_valid     = bv_q;
  assign b.bank_data      = bdata_q;
  assign b.bank_idx       = bidx_q;
  assign b.bank_last      = blast_q;
  assign b.done           = done_q;
  assign b.err            = err_q;
  assign b.busy           = state_q != IDLE;
endmodule

// File: tb/tb_wght_bank_ctrl.sv
// tb_wght_bank_ctrl: directed scenarios for the weight bank with N=4 kernels of 3x3 bytes.
module tb_wght_bank_ctrl;
  localparam int W = 8, K = 3, L = 2, C = 2, AW = 3, N = 4, KW = K*K*W;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wght_bank_ctrl_if #(.W(W), .K(K), .AW(AW)) bus ();
  wght_bank_ctrl #(.W(W), .K(K), .L(L), .C(C), .AW(AW)) dut (.clk(clk), .rst(rst), .b(bus));

  // word n of the load stream is n, so kernel k slot j holds 9k+j
  function automatic logic [KW-1:0] kern(input int k);
    logic [KW-1:0] r;
    for (int j = 0; j < K*K; j++) r[j*W +: W] = W'(K*K*k + j);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if ({bus.wr_ready, bus.write_complete, bus.loaded, bus.bank_valid, bus.bank_last} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {bus.wr_ready, bus.write_complete, bus.loaded, bus.bank_valid, bus.bank_last}); end
    checks++; if ({bus.done, bus.err, bus.busy} !== 3'b0) begin errors++; $display("FAIL reset_status got %b exp 000", {bus.done, bus.err, bus.busy}); end
    checks++; if (bus.bank_data !== '0 || bus.bank_idx !== '0) begin errors++; $display("FAIL reset_bank got %h/%0d exp 0/0", bus.bank_data, bus.bank_idx); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_start_unloaded();
    bus.start = 1'b1; bus.mode = 2'd0;
    step();
    bus.start = 1'b0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL unloaded_err got %b exp 1", bus.err); end
    checks++; if (bus.busy !== 1'b0 || bus.bank_valid !== 1'b0) begin errors++; $display("FAIL unloaded_busy got %b%b exp 00", bus.busy, bus.bank_valid); end
    step();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL unloaded_err_pulse got %b exp 0", bus.err); end
  endtask

  task automatic test_load();
    int wc_early = 0;
    bus.load_start = 1'b1; bus.start = 1'b1; bus.mode = 2'd0;
    step();
    bus.load_start = 1'b0; bus.start = 1'b0;
    checks++; if ({bus.busy, bus.wr_ready, bus.err, bus.loaded} !== 4'b1100) begin errors++; $display("FAIL collide_load got %b exp 1100", {bus.busy, bus.wr_ready, bus.err, bus.loaded}); end
    for (int n = 0; n < N*K*K; n++) begin
      bus.wr_valid = 1'b1; bus.wr_data = W'(n);
      step();
      if (n < N*K*K-1) wc_early += int'(bus.write_complete);
    end
    bus.wr_valid = 1'b0;
    checks++; if (wc_early !== 0) begin errors++; $display("FAIL load_early_wc got %0d exp 0", wc_early); end
    checks++; if ({bus.write_complete, bus.loaded, bus.busy, bus.wr_ready} !== 4'b1100) begin errors++; $display("FAIL load_complete got %b exp 1100", {bus.write_complete, bus.loaded, bus.busy, bus.wr_ready}); end
    step();
    checks++; if ({bus.write_complete, bus.loaded} !== 2'b01) begin errors++; $display("FAIL load_wc_pulse got %b exp 01", {bus.write_complete, bus.loaded}); end
  endtask

  task automatic test_sweep();
    bus.start = 1'b1; bus.mode = 2'd0;
    step();
    bus.start = 1'b0; bus.bank_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++; if (bus.bank_valid !== 1'b1 || bus.bank_idx !== AW'(i)) begin errors++; $display("FAIL sweep_idx%0d got v=%b idx=%0d exp v=1 idx=%0d", i, bus.bank_valid, bus.bank_idx, i); end
      checks++; if (bus.bank_data !== kern(i)) begin errors++; $display("FAIL sweep_data%0d got %h exp %h", i, bus.bank_data, kern(i)); end
      checks++; if (bus.bank_last !== (i == N-1)) begin errors++; $display("FAIL sweep_last%0d got %b exp %b", i, bus.bank_last, i == N-1); end
      if (i == 2) begin
        checks++; if (bus.bank_data[7:0] !== 8'd18 || bus.bank_data[71:64] !== 8'd26) begin errors++; $display("FAIL sweep_k2_words got %0d/%0d exp 18/26", bus.bank_data[7:0], bus.bank_data[71:64]); end
      end
      step();
    end
    checks++; if ({bus.done, bus.bank_valid, bus.busy} !== 3'b100) begin errors++; $display("FAIL sweep_done got %b exp 100", {bus.done, bus.bank_valid, bus.busy}); end
    bus.start = 1'b1; bus.mode = 2'd2; bus.rd_addr = AW'(1);
    step();
    bus.start = 1'b0;
    checks++; if ({bus.done, bus.bank_valid, bus.bank_last} !== 3'b011 || bus.bank_idx !== AW'(1)) begin errors++; $display("FAIL b2b_fetch got %b idx=%0d exp 011 idx=1", {bus.done, bus.bank_valid, bus.bank_last}, bus.bank_idx); end
    step();
    checks++; if ({bus.done, bus.bank_valid} !== 2'b10) begin errors++; $display("FAIL b2b_done got %b exp 10", {bus.done, bus.bank_valid}); end
    step();
  endtask

  task automatic test_backpressure();
    int k = 0;
    int c = 0;
    bus.start = 1'b1; bus.mode = 2'd0; bus.bank_ready = 1'b0;
    step();
    bus.start = 1'b0;
    while (k < N && c < 40) begin
      bus.bank_ready = (c % 2 == 0);
      checks++; if (bus.bank_valid !== 1'b1 || bus.bank_idx !== AW'(k) || bus.bank_data !== kern(k)) begin errors++; $display("FAIL bp_cycle%0d got v=%b idx=%0d exp v=1 idx=%0d", c, bus.bank_valid, bus.bank_idx, k); end
      if (bus.bank_valid && bus.bank_ready) k++;
      step();
      c++;
    end
    bus.bank_ready = 1'b1;
    checks++; if (k !== N) begin errors++; $display("FAIL bp_handshakes got %0d exp %0d", k, N); end
    checks++; if (bus.done !== 1'b1 || bus.bank_valid !== 1'b0) begin errors++; $display("FAIL bp_done got %b%b exp 10", bus.done, bus.bank_valid); end
    step();
  endtask

  task automatic test_loop();
    bus.start = 1'b1; bus.mode = 2'd1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      checks++; if (bus.bank_valid !== 1'b1 || bus.bank_idx !== AW'(i % N) || bus.bank_last !== (i % N == N-1)) begin errors++; $display("FAIL loop_k%0d got v=%b idx=%0d last=%b exp idx=%0d", i, bus.bank_valid, bus.bank_idx, bus.bank_last, i % N); end
      bus.stop = (i == 5);
      step();
    end
    bus.stop = 1'b0;
    checks++; if ({bus.done, bus.bank_valid, bus.busy} !== 3'b100) begin errors++; $display("FAIL loop_done got %b exp 100", {bus.done, bus.bank_valid, bus.busy}); end
    step();
  endtask

  task automatic test_fetch();
    bus.start = 1'b1; bus.mode = 2'd2; bus.rd_addr = AW'(3); bus.bank_ready = 1'b0;
    step();
    bus.start = 1'b0;
    checks++; if ({bus.bank_valid, bus.bank_last} !== 2'b11 || bus.bank_idx !== AW'(3) || bus.bank_data[7:0] !== 8'd27) begin errors++; $display("FAIL fetch3 got v/l=%b idx=%0d w0=%0d exp 11 idx=3 w0=27", {bus.bank_valid, bus.bank_last}, bus.bank_idx, bus.bank_data[7:0]); end
    bus.bank_ready = 1'b1;
    step();
    checks++; if ({bus.done, bus.bank_valid} !== 2'b10) begin errors++; $display("FAIL fetch3_done got %b exp 10", {bus.done, bus.bank_valid}); end
    bus.start = 1'b1; bus.rd_addr = AW'(4);
    step();
    bus.start = 1'b0;
    checks++; if ({bus.err, bus.bank_valid, bus.busy} !== 3'b100) begin errors++; $display("FAIL fetch4_err got %b exp 100", {bus.err, bus.bank_valid, bus.busy}); end
    step();
  endtask

  task automatic test_reset_mid_read();
    bus.start = 1'b1; bus.mode = 2'd0; bus.bank_ready = 1'b0;
    step();
    bus.start = 1'b0;
    checks++; if (bus.bank_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b%b exp 11", bus.bank_valid, bus.busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.bank_valid, bus.busy, bus.loaded, bus.bank_last, bus.wr_ready} !== 5'b0 || bus.bank_data !== '0) begin errors++; $display("FAIL rstmid_async got %b data=%h exp 00000 data=0", {bus.bank_valid, bus.busy, bus.loaded, bus.bank_last, bus.wr_ready}, bus.bank_data); end
    #1 rst = 1'b1;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if ({bus.err, bus.busy, bus.bank_valid} !== 3'b100) begin errors++; $display("FAIL rstmid_start got %b exp 100", {bus.err, bus.busy, bus.bank_valid}); end
  endtask

  initial begin
    bus.load_start = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0; bus.start = 1'b0;
    bus.mode = 2'd0; bus.rd_addr = '0; bus.stop = 1'b0; bus.bank_ready = 1'b0;
    test_reset();
    test_start_unloaded();
    test_load();
    test_sweep();
    test_backpressure();
    test_loop();
    test_fetch();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
